// File: rtl/if_stage.sv
// if_stage: instruction fetch with PC register, IF/ID pipeline register, stall/flush/redirect and backpressure.
// Optional performance counters are enabled by defining IF_PERF_CNT_EN.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_rdata_i,
    output logic        id_valid_o,
    input  logic        id_ready_i,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_pc4_o,
    output logic [31:0] id_instr_o
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetch_o,
    output logic [31:0] perf_bubble_o
`endif
);
    logic [31:0] pc_q, pc_d, pc_next_seq;
    logic        valid_q, valid_d;
    logic [31:0] id_pc_q, id_pc_d, id_pc4_q, id_pc4_d, id_instr_q, id_instr_d;
    logic        load, consume, capture;

    assign pc_next_seq = pc_q + PC_STEP;
    assign load        = ~stall_i & (~valid_q | id_ready_i);
    assign consume     = valid_q & id_ready_i;
    // only a clean load (no redirect, no flush) writes the IF/ID payload
    assign capture     = load & ~redirect_valid_i & ~flush_i;

    always_comb begin
        pc_d       = redirect_valid_i ? redirect_pc_i : (load ? pc_next_seq : pc_q);
        valid_d    = (redirect_valid_i | flush_i) ? 1'b0 :
                     load ? 1'b1 : (consume ? 1'b0 : valid_q);
        id_pc_d    = capture ? pc_q : id_pc_q;
        id_pc4_d   = capture ? pc_next_seq : id_pc4_q;
        id_instr_d = capture ? imem_rdata_i : id_instr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            valid_q    <= 1'b0;
            id_pc_q    <= '0;
            id_pc4_q   <= '0;
            id_instr_q <= '0;
        end else begin
            pc_q       <= pc_d;
            valid_q    <= valid_d;
            id_pc_q    <= id_pc_d;
            id_pc4_q   <= id_pc4_d;
            id_instr_q <= id_instr_d;
        end
    end

    assign imem_addr_o = pc_q;
    assign id_valid_o  = valid_q;
    assign id_pc_o     = id_pc_q;
    assign id_pc4_o    = id_pc4_q;
    assign id_instr_o  = id_instr_q;

`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetch_q, perf_bubble_q;

    // a bubble is any edge after which decode sees no valid entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_q  <= '0;
            perf_bubble_q <= '0;
        end else begin
            perf_fetch_q  <= perf_fetch_q + {31'd0, capture};
            perf_bubble_q <= perf_bubble_q + {31'd0, ~valid_d};
        end
    end

    assign perf_fetch_o  = perf_fetch_q;
    assign perf_bubble_o = perf_bubble_q;
`endif
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed stimulus with a scoreboard queue checked by a handshake monitor.
module tb_if_stage;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        stall, flush, redir, ready;
    logic [31:0] rpc;
    logic [31:0] addr, rdata, id_pc, id_pc4, id_instr;
    logic        id_valid;
    logic [31:0] addr2, rdata2, id_pc2, id_pc42, id_instr2;
    logic        id_valid2;
`ifdef IF_PERF_CNT_EN
    logic [31:0] pf, pb, pf2, pb2;
`endif
    int total = 0;
    int bad = 0;
    logic [95:0] exp_q[$];

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    assign rdata  = mem(addr);
    assign rdata2 = mem(addr2);

    if_stage dut (
        .clk(clk), .rst_n(rst_n), .stall_i(stall), .flush_i(flush),
        .redirect_valid_i(redir), .redirect_pc_i(rpc), .imem_addr_o(addr),
        .imem_rdata_i(rdata), .id_valid_o(id_valid), .id_ready_i(ready),
        .id_pc_o(id_pc), .id_pc4_o(id_pc4), .id_instr_o(id_instr)
`ifdef IF_PERF_CNT_EN
        , .perf_fetch_o(pf), .perf_bubble_o(pb)
`endif
    );

    if_stage #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
        .clk(clk), .rst_n(rst_n), .stall_i(stall), .flush_i(flush),
        .redirect_valid_i(redir), .redirect_pc_i(rpc), .imem_addr_o(addr2),
        .imem_rdata_i(rdata2), .id_valid_o(id_valid2), .id_ready_i(ready),
        .id_pc_o(id_pc2), .id_pc4_o(id_pc42), .id_instr_o(id_instr2)
`ifdef IF_PERF_CNT_EN
        , .perf_fetch_o(pf2), .perf_bubble_o(pb2)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] pc);
        exp_q.push_back({pc, pc + 32'd4, mem(pc)});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // an entry leaves IF/ID on an edge where it is valid, accepted and not killed
    always @(negedge clk) begin
        if (rst_n && id_valid && ready && !redir && !flush) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_handshake got=%h want=none", id_pc);
            end else begin
                logic [95:0] e;
                e = exp_q.pop_front();
                chk("hs_pc", id_pc, e[95:64]);
                chk("hs_pc4", id_pc4, e[63:32]);
                chk("hs_instr", id_instr, e[31:0]);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        stall = 0; flush = 0; redir = 0; rpc = 0; ready = 0;
        rst_n = 1'b0;
        step();
        chk("rst_valid", {31'd0, id_valid}, 32'd0);
        chk("rst_pc", id_pc, 32'd0);
        chk("rst_pc4", id_pc4, 32'd0);
        chk("rst_instr", id_instr, 32'd0);
        chk("rst_addr", addr, 32'h3000);
        chk("rst_addr2", addr2, 32'hFFFF_FFFC);
        rst_n = 1'b1;
        ready = 1;
        for (int i = 0; i < 4; i++) begin
            chk("seq_addr", addr, 32'h3000 + 32'(4 * i));
            push(32'h3000 + 32'(4 * i));
            step();
        end
        ready = 0;
        repeat (3) begin
            step();
            chk("bp_valid", {31'd0, id_valid}, 32'd1);
            chk("bp_pc", id_pc, 32'h300C);
            chk("bp_pc4", id_pc4, 32'h3010);
            chk("bp_instr", id_instr, mem(32'h300C));
            chk("bp_addr", addr, 32'h3010);
        end
        ready = 1;
        push(32'h3010);
        step();
        stall = 1;
        step();
        chk("cons_valid", {31'd0, id_valid}, 32'd0);
        chk("cons_addr", addr, 32'h3014);
        redir = 1; rpc = 32'h4000; ready = 0;
        step();
        chk("redir_valid", {31'd0, id_valid}, 32'd0);
        chk("redir_addr", addr, 32'h4000);
        redir = 0; stall = 0; ready = 1;
        push(32'h4000);
        step();
        chk("redir_tgt_valid", {31'd0, id_valid}, 32'd1);
        chk("redir_tgt_pc", id_pc, 32'h4000);
        stall = 1;
        step();
        chk("stall_valid", {31'd0, id_valid}, 32'd0);
        chk("stall_addr", addr, 32'h4004);
        stall = 0; ready = 0;
        step();
        chk("pre_flush_pc", id_pc, 32'h4004);
        chk("pre_flush_addr", addr, 32'h4008);
        flush = 1; stall = 1;
        step();
        chk("flush_valid", {31'd0, id_valid}, 32'd0);
        chk("flush_hold_addr", addr, 32'h4008);
        stall = 0;
        step();
        chk("flush_load_valid", {31'd0, id_valid}, 32'd0);
        chk("flush_load_addr", addr, 32'h400C);
        redir = 1; rpc = 32'h5000;
        step();
        chk("redir_flush_valid", {31'd0, id_valid}, 32'd0);
        chk("redir_flush_addr", addr, 32'h5000);
        redir = 0; flush = 0; ready = 1;
        for (int i = 0; i < 3; i++) begin
            push(32'h5000 + 32'(4 * i));
            step();
        end
        chk("thru_pc", id_pc, 32'h5008);
        stall = 1;
        step();
        chk("drain_valid", {31'd0, id_valid}, 32'd0);
        stall = 0;
        step();
        #2 rst_n = 1'b0;
        #1;
        chk("async_valid", {31'd0, id_valid}, 32'd0);
        chk("async_pc", id_pc, 32'd0);
        chk("async_addr", addr, 32'h3000);
`ifdef IF_PERF_CNT_EN
        chk("async_perf", pf, 32'd0);
`endif
        step();
        rst_n = 1'b1;
        chk("wrap_start_addr", addr2, 32'hFFFF_FFFC);
        for (int i = 0; i < 10; i++) begin
            chk("re_addr", addr, 32'h3000 + 32'(4 * i));
            push(32'h3000 + 32'(4 * i));
            step();
            if (i == 0) begin
                chk("wrap_pc", id_pc2, 32'hFFFF_FFFC);
                chk("wrap_pc4", id_pc42, 32'h0);
                chk("wrap_addr", addr2, 32'h0);
            end
            if (i == 1) begin
                chk("wrap_pc_b", id_pc2, 32'h0);
                chk("wrap_pc4_b", id_pc42, 32'h4);
            end
        end
        stall = 1;
        repeat (3) step();
        chk("end_valid", {31'd0, id_valid}, 32'd0);
`ifdef IF_PERF_CNT_EN
        chk("perf_fetch", pf, 32'd10);
        chk("perf_bubble_ge3", {31'd0, pb >= 32'd3}, 32'd1);
`endif
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
